// File: rtl/pipo_rr_arbiter_if.sv
// Requester/downstream bundle for pipo_rr_arbiter: request words in, one held word out.
interface pipo_rr_arbiter_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N_REQ = 4
) ();
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;

  modport master (
    output req, req_data, out_ready,
    input  gnt, out_data, out_valid, busy
  );

  modport slave (
    input  req, req_data, out_ready,
    output gnt, out_data, out_valid, busy
  );
endinterface

// File: rtl/pipo_rr_arbiter.sv
// Round-robin arbiter loading one shared PIPO holding register with valid/ready output.
// Optional per-requester grant counters under macro PIPO_ARB_STATS_EN.
module pipo_rr_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef PIPO_ARB_STATS_EN
  input  logic [$clog2(N_REQ)-1:0]   stat_sel,
  output logic [7:0]                 stat_count,
`endif
  pipo_rr_arbiter_if.slave           bus
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   win;
  logic               found;
  logic               accept;
  logic               grant;
  logic [N_REQ-1:0]   gnt_c;
  logic [WIDTH-1:0]   out_data_q;
  logic [WIDTH-1:0]   win_data;

  // Winner: first active request scanning upward from the slot after the last grant.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      int unsigned idx;
      idx = (32'(ptr) + k) % N_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  assign win_data = bus.req_data[32'(win)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EMPTY;
      out_data_q <= '0;
      ptr        <= PTR_W'(N_REQ - 1);
    end else begin
      state <= state_nxt;
      if (grant) begin
        out_data_q <= win_data;
        ptr        <= win;
      end
    end
  end

  // A full register accepts a new word in the same cycle it drains; reset masks the grant.
  always_comb begin
    state_nxt = state;
    gnt_c     = '0;
    accept    = (state == EMPTY) || bus.out_ready;
    grant     = accept && found && rst;
    if (grant) begin
      gnt_c[win] = 1'b1;
    end
    case (state)
      EMPTY: if (grant) state_nxt = FULL;
      FULL:  if (bus.out_ready && !grant) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  assign bus.gnt       = gnt_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = (state == FULL);
  assign bus.busy      = (state == FULL) || (|bus.req);

`ifdef PIPO_ARB_STATS_EN
  logic [7:0] cnt [N_REQ];

  // Saturating grant counters, one per requester.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (gnt_c[i] && (cnt[i] != 8'hFF)) begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    stat_count = '0;
    if (32'(stat_sel) < N_REQ) begin
      stat_count = cnt[stat_sel];
    end
  end
`endif

endmodule
